gc_block_config_responder: RTL

//  Target side of the global-controller configuration sequencer. One instance per

---
 rtl/gc_block_config_responder_if.sv | 40 ++++
 rtl/gc_block_config_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gc_block_config_responder_if.sv
// Purpose : sequencer/memory-facing bundle of one configuration responder.
// Latency : wires only.
// Backpressure: none; the memory answers every strobe after a fixed latency.
// Ports (slave view, i.e. the responder):
//   current_select in  select code from the sequencer
//   pdone          in  configuration memory populated
//   mem_rd_en      out memory read strobe
//   mem_addr       out memory read address
//   mem_rdata      in  read data, valid a fixed number of cycles after mem_rd_en
//   conf_ack       out one-cycle completion pulse to the sequencer
//   cfg_busy       out load in progress
//   cfg_valid      out register bank holds a complete load
//   cfg_regs       out register bank, word i at [i*DATA_WIDTH +: DATA_WIDTH]
interface gc_block_config_responder_if #(
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [2:0]                      current_select;
  logic                            pdone;
  logic                            mem_rd_en;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            conf_ack;
  logic                            cfg_busy;
  logic                            cfg_valid;
  logic [NUM_WORDS*DATA_WIDTH-1:0] cfg_regs;

  // Responder side.
  modport slave (
    input  current_select, pdone, mem_rdata,
    output mem_rd_en, mem_addr, conf_ack, cfg_busy, cfg_valid, cfg_regs
  );

  // Sequencer + memory side.
  modport master (
    output current_select, pdone, mem_rdata,
    input  mem_rd_en, mem_addr, conf_ack, cfg_busy, cfg_valid, cfg_regs
  );
endinterface

// File: rtl/gc_block_config_responder.sv
// Purpose : loads NUM_WORDS words from the configuration memory into a local register
//           bank when the sequencer selects BLOCK_ID, then pulses conf_ack once.
// Latency : first strobe 1 cycle after sel&&pdone; conf_ack NUM_WORDS+RD_LATENCY cycles
//           after the first strobe.
// Backpressure: none; one strobe per cycle, the memory must answer each after
//           RD_LATENCY cycles. Dropping the select aborts the load.
// Ports: conf_clk / reset_n (async, active low) plus the slave modport of
//        gc_block_config_responder_if (select, pdone, read port, ack, status, bank).
module gc_block_config_responder #(
  parameter logic [2:0]            BLOCK_ID   = 3'b001,
  parameter int unsigned           NUM_WORDS  = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_LATENCY = 1
) (
  input  logic                         conf_clk,
  input  logic                         reset_n,
  gc_block_config_responder_if.slave   bus
);

  localparam int unsigned IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam int unsigned REGS_W   = NUM_WORDS * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_ACK   = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e                  state_q,     state_d;
  logic [IDX_W-1:0]        issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]        wr_idx_q,    wr_idx_d;
  logic [RD_LATENCY-1:0]   pipe_q,      pipe_d;
  logic [REGS_W-1:0]       cfg_regs_q,  cfg_regs_d;
  logic                    cfg_valid_q, cfg_valid_d;

  logic sel;
  logic rd_en;
  logic loading;
  logic capture;

  assign sel     = (bus.current_select == BLOCK_ID);
  assign rd_en   = (state_q == S_READ);
  assign loading = (state_q == S_READ) || (state_q == S_DRAIN);
  // Returning read data is only accepted while the load is still selected;
  // on the aborting edge the in-flight word is discarded with the rest.
  assign capture = pipe_q[RD_LATENCY-1] && loading && sel;

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    wr_idx_d    = wr_idx_q;
    cfg_regs_d  = cfg_regs_q;
    cfg_valid_d = cfg_valid_q;

    // Valid shift register mirrors the memory latency: a bit enters with each
    // strobe and leaves exactly when that strobe's data is on mem_rdata.
    pipe_d    = '0;
    pipe_d[0] = rd_en && sel;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (capture) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        if (wr_idx_q == IDX_W'(i)) begin
          cfg_regs_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
        end
      end
      wr_idx_d = wr_idx_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (sel && bus.pdone) begin
          state_d     = S_READ;
          issue_idx_d = '0;
          wr_idx_d    = '0;
          cfg_valid_d = 1'b0;
        end
      end
      S_READ: begin
        if (!sel) begin
          state_d = S_IDLE;
          pipe_d  = '0;
        end else begin
          issue_idx_d = issue_idx_q + 1'b1;
          if (issue_idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!sel) begin
          state_d = S_IDLE;
          pipe_d  = '0;
        end else if (capture && (wr_idx_q == LAST_IDX)) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        cfg_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // A select that stays asserted must not retrigger a load.
        if (!sel) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge conf_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      issue_idx_q <= '0;
      wr_idx_q    <= '0;
      pipe_q      <= '0;
      cfg_regs_q  <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      wr_idx_q    <= wr_idx_d;
      pipe_q      <= pipe_d;
      cfg_regs_q  <= cfg_regs_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  // Address wraps modulo 2^ADDR_WIDTH, so a block may straddle the top of memory.
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? (BASE_ADDR + ADDR_WIDTH'(issue_idx_q)) : '0;
  assign bus.conf_ack  = (state_q == S_ACK);
  assign bus.cfg_busy  = loading;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.cfg_regs  = cfg_regs_q;

endmodule
